gmii_rx_frame: RTL
==================

// Module: gmii_rx_frame
// PURPOSE
//  Consumes the GMII byte stream (gmii_rx_clk/gmii_rx_dv/gmii_rxd) from the RGMII->GMII receive stage.
//  Strips preamble/SFD, checks FCS (CRC-32), filters destination MAC, withholds the 4 FCS bytes.
//  Emits one byte per cycle plus a per-frame status pulse.
//  Feeds the UDP/IP parser; runs entirely in the gmii_rx_clk domain.
// PARAMETERS
//  LOCAL_MAC  48'h00_11_22_33_44_55  station address; dest match = LOCAL_MAC or FF:FF:FF:FF:FF:FF
//  MIN_LEN    64                     minimum frame bytes incl. FCS; shorter frames flagged runt
//  MAX_LEN    1518                   maximum frame bytes incl. FCS; longer frames truncated and flagged
// PORTS
//  gmii_rx_clk     in   1   receive clock, all logic on rising edge
//  rst             in   1   reset; asynchronous, active-high
//  gmii_rx_dv      in   1   GMII receive data valid
//  gmii_rxd        in   8   GMII receive data
//  rx_data         out  8   frame byte (dest MAC .. last payload byte, FCS excluded)
//  rx_valid        out  1   rx_data valid this cycle
//  rx_sof          out  1   with rx_valid on first byte (dest MAC[47:40])
//  rx_done         out  1   one-cycle end-of-frame pulse; status ports valid this cycle
//  rx_len          out  11  bytes delivered on rx_data for the frame (total minus 4, floor 0)
//  rx_crc_ok       out  1   FCS correct (0 if oversize)
//  rx_addr_match   out  1   dest MAC equals LOCAL_MAC or broadcast (0 if <6 bytes)
//  rx_runt         out  1   total bytes incl. FCS < MIN_LEN
//  rx_oversize     out  1   total bytes incl. FCS > MAX_LEN
//  frames_ok       out  16  count of done frames with crc_ok & ~runt & ~oversize; wraps
//  frames_bad      out  16  count of all other done frames; wraps
// BEHAVIOUR
//  Reset
//   - All outputs and counters 0.
//   - FSM = IDLE; dv_q (registered dv) = 1, so a frame already in progress at reset release is ignored.
//  FSM
//   IDLE:  dv_q==0 & dv==1 -> PRE, evaluating the current byte as a preamble byte.
//   PRE:   byte 0x55 -> stay.
//          byte 0xD5 after >=1 0x55 -> DATA, count=0.
//          any other byte, or 0xD5 with no prior 0x55 -> DROP.
//          dv==0 -> IDLE, no rx_done.
//   DATA:  each dv byte: count++ (saturates at 2047), CRC update, 4-byte delay line shift.
//          dv==0 -> IDLE, rx_done next cycle.
//          count would exceed MAX_LEN -> TRUNC.
//   TRUNC: no rx_valid, no CRC update.
//          dv==0 -> IDLE, rx_done next cycle with rx_oversize=1, rx_crc_ok=0.
//   DROP:  wait dv==0 -> IDLE, no rx_done, no counter update.
//  Data path
//   - Byte k (k=0 first after SFD) goes out registered on rx_data/rx_valid in the cycle after byte k+4 is sampled.
//   - The last 4 bytes held at dv fall are the FCS and are discarded (cleared, never output).
//   - rx_valid is never high for a frame with <=4 bytes.
//  CRC
//   - Reflected poly 0xEDB88320, LSB-first, init 0xFFFFFFFF on SFD, updated over every DATA byte incl. FCS.
//   - crc_ok iff register == 0xDEBB20E3 at dv fall.
//  Address match
//   - Compares bytes 0..5 against LOCAL_MAC (byte 0 = [47:40]).
//   - Any mismatch clears a running match flag for both unicast and broadcast.
//  rx_done
//   - Exactly one cycle, the cycle after dv samples low in DATA/TRUNC.
//   - All status ports hold their value until the next rx_done.
//   - Counters update on rx_done.
//  Back-to-back frames: dv low for a single cycle between frames is supported; rx_done and the new PRE may overlap.
//  gmii_rx_dv high with no preamble (junk) is handled by DROP; no output.
// TESTING
//  1. Preamble 7x55+D5, 60-byte broadcast ARP + valid FCS
//     -> 60 rx_valid beats, sof on first; rx_done with len=60, crc_ok=1, addr_match=1, runt=0; frames_ok=1.
//  2. Same frame with one FCS bit flipped
//     -> identical data out; rx_done with crc_ok=0; frames_bad=1, frames_ok unchanged.
//  3. Dest 00:11:22:33:44:56, 40 bytes total incl. valid FCS
//     -> len=36, addr_match=0, runt=1, crc_ok=1; frames_bad++.
//  4. Preamble 55 55 A5 then 60 bytes
//     -> DROP: no rx_valid, no rx_done, counters unchanged; next good frame received normally.
//  5. 1600-byte frame
//     -> exactly MAX_LEN-4=1514 beats; rx_done with oversize=1, crc_ok=0, len=1514.
//  6. rst asserted mid-frame (byte 30), released while dv still high
//     -> outputs 0 immediately; rest of that frame ignored; next frame after dv low decoded correctly.

Source files
------------

// File: rtl/gmii_rx_frame.sv
// gmii_rx_frame
//   GMII receive framer. It strips the preamble and SFD, runs CRC-32 over the
//   frame, checks the destination MAC and holds bytes back in a 4-byte delay
//   line so that the trailing FCS is never presented downstream.
//   Everything runs in the gmii_rx_clk domain.
// Ports
//   gmii_rx_clk, rst            clock, async active-high reset
//   gmii_rx_dv, gmii_rxd        GMII receive stream
//   rx_data/rx_valid/rx_sof     frame bytes (dest MAC .. last payload byte)
//   rx_done                     1-cycle end-of-frame pulse, status valid/held
//   rx_len, rx_crc_ok, rx_addr_match, rx_runt, rx_oversize   frame status
//   frames_ok, frames_bad       wrapping frame counters
module gmii_rx_frame #(
  parameter logic [47:0] LOCAL_MAC = 48'h00_11_22_33_44_55,
  parameter int          MIN_LEN   = 64,
  parameter int          MAX_LEN   = 1518
) (
  input  logic        gmii_rx_clk,
  input  logic        rst,
  input  logic        gmii_rx_dv,
  input  logic [7:0]  gmii_rxd,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_sof,
  output logic        rx_done,
  output logic [10:0] rx_len,
  output logic        rx_crc_ok,
  output logic        rx_addr_match,
  output logic        rx_runt,
  output logic        rx_oversize,
  output logic [15:0] frames_ok,
  output logic [15:0] frames_bad
);

  localparam logic [2:0]  S_IDLE  = 3'd0;
  localparam logic [2:0]  S_PRE   = 3'd1;
  localparam logic [2:0]  S_DATA  = 3'd2;
  localparam logic [2:0]  S_TRUNC = 3'd3;
  localparam logic [2:0]  S_DROP  = 3'd4;

  localparam logic [10:0] MIN_L       = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L       = 11'(MAX_LEN);
  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  logic [2:0]       state;
  logic             dv_q;
  logic [10:0]      count;
  logic [31:0]      crc;
  logic [31:0]      crc_next;
  logic [3:0][7:0]  dly;        // dly[3] is the oldest byte
  logic             uc_match;
  logic             bc_match;
  logic [7:0]       mac_byte;

  logic             end_frame;
  logic             trunc;
  logic [10:0]      len_calc;
  logic             crc_good;
  logic             addr_hit;
  logic             runt;
  logic             frame_good;

  // Byte-wide reflected CRC step, LSB first.
  always_comb begin
    crc_next = crc ^ {24'h0, gmii_rxd};
    for (int i = 0; i < 8; i++)
      crc_next = crc_next[0] ? ((crc_next >> 1) ^ CRC_POLY) : (crc_next >> 1);
  end

  // Station address byte expected at the current frame offset (0..5).
  always_comb begin
    mac_byte = 8'h00;
    case (count[2:0])
      3'd0:    mac_byte = LOCAL_MAC[47:40];
      3'd1:    mac_byte = LOCAL_MAC[39:32];
      3'd2:    mac_byte = LOCAL_MAC[31:24];
      3'd3:    mac_byte = LOCAL_MAC[23:16];
      3'd4:    mac_byte = LOCAL_MAC[15:8];
      3'd5:    mac_byte = LOCAL_MAC[7:0];
      default: mac_byte = 8'h00;
    endcase
  end

  // Status for the frame that is closing this cycle (dv just dropped).
  always_comb begin
    end_frame  = !gmii_rx_dv && (state == S_DATA || state == S_TRUNC);
    trunc      = (state == S_TRUNC);
    len_calc   = (count > 11'd4) ? (count - 11'd4) : 11'd0;
    crc_good   = (crc == CRC_RESIDUE) && !trunc;
    addr_hit   = (count >= 11'd6) && (uc_match || bc_match);
    runt       = (count < MIN_L);
    frame_good = crc_good && !runt && !trunc;
  end

  always_ff @(posedge gmii_rx_clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      dv_q          <= 1'b1;   // a frame already running at release is skipped
      count         <= '0;
      crc           <= '1;
      dly           <= '0;
      uc_match      <= 1'b0;
      bc_match      <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_sof        <= 1'b0;
      rx_done       <= 1'b0;
      rx_len        <= '0;
      rx_crc_ok     <= 1'b0;
      rx_addr_match <= 1'b0;
      rx_runt       <= 1'b0;
      rx_oversize   <= 1'b0;
      frames_ok     <= '0;
      frames_bad    <= '0;
    end else begin
      dv_q     <= gmii_rx_dv;
      rx_valid <= 1'b0;
      rx_sof   <= 1'b0;
      rx_done  <= 1'b0;

      if (end_frame) begin
        rx_done       <= 1'b1;
        rx_len        <= len_calc;
        rx_crc_ok     <= crc_good;
        rx_addr_match <= addr_hit;
        rx_runt       <= runt;
        rx_oversize   <= trunc;
        dly           <= '0;   // FCS bytes left in the line are discarded
        if (frame_good) frames_ok  <= frames_ok + 16'd1;
        else            frames_bad <= frames_bad + 16'd1;
      end

      case (state)
        S_IDLE: begin
          // Only a fresh dv rise starts a frame; first byte counts as preamble.
          if (!dv_q && gmii_rx_dv)
            state <= (gmii_rxd == 8'h55) ? S_PRE : S_DROP;
        end
        S_PRE: begin
          if (!gmii_rx_dv) begin
            state <= S_IDLE;
          end else if (gmii_rxd == 8'hD5) begin
            state    <= S_DATA;
            count    <= '0;
            crc      <= '1;
            uc_match <= 1'b1;
            bc_match <= 1'b1;
          end else if (gmii_rxd != 8'h55) begin
            state <= S_DROP;
          end
        end
        S_DATA: begin
          if (!gmii_rx_dv) begin
            state <= S_IDLE;
          end else if (count >= MAX_L) begin
            state <= S_TRUNC;
          end else begin
            count <= (count == 11'h7FF) ? count : count + 11'd1;
            crc   <= crc_next;
            dly   <= {dly[2:0], gmii_rxd};
            // Once four bytes are buffered, each new byte releases the oldest.
            if (count >= 11'd4) begin
              rx_data  <= dly[3];
              rx_valid <= 1'b1;
              rx_sof   <= (count == 11'd4);
            end
            if (count < 11'd6) begin
              if (gmii_rxd != mac_byte) uc_match <= 1'b0;
              if (gmii_rxd != 8'hFF)    bc_match <= 1'b0;
            end
          end
        end
        S_TRUNC: begin
          if (!gmii_rx_dv) state <= S_IDLE;
        end
        S_DROP: begin
          if (!gmii_rx_dv) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
